// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port memory between the core
// fetch port and a program loader/debug port, with a load-mode state machine.
module imem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_STARVE);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state and grants; arbitration follows the current (registered) state,
  // so the cycle in which load_mode rises still arbitrates under RUN rules.
  always_comb begin
    state_nxt = state;
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    case (state)
      RUN: begin
        if (load_mode) state_nxt = LOAD;
        if (f_req && l_req) begin
          if (starve_cnt == MAX_CNT) l_gnt = 1'b1;
          else                       f_gnt = 1'b1;
        end else begin
          f_gnt = f_req;
          l_gnt = l_req;
        end
      end
      LOAD: begin
        if (!load_mode) state_nxt = FLUSH;
        l_gnt = l_req;
      end
      FLUSH: begin
        state_nxt = load_mode ? LOAD : RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || l_gnt || !l_req)
      starve_cnt <= '0;
    else if (f_gnt && starve_cnt != MAX_CNT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (l_gnt) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      mem_we    = l_we;
    end else if (f_gnt) begin
      mem_addr  = f_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      f_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      f_rdata  <= '0;
      l_rdata  <= '0;
    end else begin
      f_rvalid <= f_gnt;
      l_rvalid <= l_gnt;
      if (f_gnt) f_rdata <= mem_rdata;
      if (l_gnt) l_rdata <= l_we ? '0 : mem_rdata;
    end
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port instruction memory between the core fetch port and a program loader/debug port. The memory has a combinational read (address in, instruction out) and a synchronous write.
- Grants one requester per cycle.
- Drives the memory address, write data and write enable.
- Returns registered read responses one cycle after grant.
- A load-mode state machine blocks fetch while a program is being written, then inserts a one-cycle flush bubble before fetch resumes.

Parameters:
ADDR_W, 32, address width (word index, consecutive instructions at consecutive addresses)
DATA_W, 32, instruction/data width
MAX_STARVE, 4, consecutive fetch grants allowed while loader is pending before loader is forced a slot (range 1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
load_mode  in  1  1 = loader owns memory, fetch blocked
f_req  in  1  fetch request
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch granted this cycle (combinational)
f_rvalid  out  1  fetch response valid (registered)
f_rdata  out  DATA_W  fetched instruction (registered)
l_req  in  1  loader request
l_we  in  1  loader write (1) / read (0)
l_addr  in  ADDR_W  loader address
l_wdata  in  DATA_W  loader write data
l_gnt  out  1  loader granted this cycle (combinational)
l_rvalid  out  1  loader response/ack valid (registered)
l_rdata  out  DATA_W  loader read data (registered)
mem_addr  out  ADDR_W  to instruction memory
mem_wdata  out  DATA_W  to instruction memory
mem_we  out  1  memory write enable
mem_rdata  in  DATA_W  combinational read data from memory

Behaviour:
- Clock and reset: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset state and outputs:
  - State = RUN, starve_cnt = 0.
  - f_rvalid = l_rvalid = 0; f_rdata = l_rdata = 0.
  - With no requests: f_gnt = l_gnt = 0, mem_we = 0.
- States:
  - RUN: normal arbitration.
  - LOAD: loader only; f_gnt forced 0.
  - FLUSH: one cycle, no grants to either port.
- Transitions:
  - RUN -> LOAD when load_mode = 1 (sampled at the edge; the arbitration in the cycle load_mode rises still follows RUN rules).
  - LOAD -> FLUSH when load_mode = 0.
  - FLUSH -> RUN unconditionally; if load_mode = 1 during FLUSH, go to LOAD instead.
- Arbitration in RUN:
  - Only one requester: it is granted.
  - Both requesting: fetch wins, unless starve_cnt == MAX_STARVE, in which case loader wins.
- Arbitration in LOAD: l_gnt = l_req.
- starve_cnt:
  - Increments (saturating at MAX_STARVE) on each edge where f_gnt = 1 and l_req = 1.
  - Clears on any loader grant, or on any edge where l_req = 0.
- Memory mux (combinational):
  - Fetch grant: mem_addr = f_addr.
  - Loader grant: mem_addr = l_addr, mem_wdata = l_wdata, mem_we = l_we.
  - No grant: mem_addr = 0, mem_wdata = 0, mem_we = 0.
  - mem_we is never 1 without l_gnt.
- Latency: exactly 1 cycle.
  - f_rvalid = 1 in the cycle after f_gnt; f_rdata = mem_rdata captured at the grant edge.
  - l_rvalid = 1 in the cycle after l_gnt, for reads and for writes (write ack).
  - l_rdata = mem_rdata for reads, 0 for writes.
- rdata hold: f_rdata and l_rdata hold their last value when rvalid = 0. Each rvalid is a single-cycle pulse per grant; back-to-back grants produce back-to-back pulses.
- A fetch granted in the cycle before entering LOAD still returns its response in the first LOAD cycle.
- Read-after-write: a loader write followed by a read of the same address on the next cycle returns the new data (the memory writes at the edge).
- Reset mid-operation: a response for a grant made in the cycle reset is asserted is dropped. State returns to RUN even if load_mode = 1 (re-enters LOAD on the next edge).

Test Plan:
- Fetch only: memory preloaded with 0x00500093, 0x00A00113, 0x002081B3, 0x40208233 at addresses 0..3; f_req = 1, f_addr = 0,1,2,3 -> f_gnt = 1 each cycle; f_rvalid pulses with f_rdata matching each word one cycle later.
- Load then fetch: load_mode = 1; loader writes 0xDEADBEEF @0 and 0x00000013 @1; load_mode = 0 -> one FLUSH cycle with f_gnt = 0 while f_req = 1; fetch @0 then returns 0xDEADBEEF, fetch @1 returns 0x00000013.
- Fetch blocked in LOAD: f_req = 1 throughout LOAD -> f_gnt = 0, mem_we only with l_gnt; l_rvalid = 1 the cycle after each write, with l_rdata = 0.
- Starvation: RUN, f_req = l_req = 1 continuously, MAX_STARVE = 4 -> 4 fetch grants, then 1 loader grant, then the pattern repeats.
- Loader read in RUN while f_req = 0: l_addr = 2 -> l_rdata = 0x002081B3 one cycle later; l_rvalid is a single-cycle pulse.
- Reset mid-load: assert reset during a LOAD write grant with load_mode = 1 -> next cycle l_rvalid = 0, state RUN; the following cycle state LOAD.
